// File: rtl/riscv_mem_pkg.sv
// ------------------------------------------------------------------------
// riscv_mem_pkg: shared types/widths for the memory port arbiter. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package riscv_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_id_t;

endpackage

`default_nettype wire

// File: rtl/outstanding_tracker.sv
// ------------------------------------------------------------------------
// outstanding_tracker: in-order FIFO of source IDs for issued requests. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module outstanding_tracker
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  src_id_t                      push_id,
  input  logic                         pop,
  output src_id_t                      pop_id,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  src_id_t       r_ids [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign pop_id    = r_ids[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_ids[r_wr_ptr] <= push_id;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ------------------------------------------------------------------------
// mem_port_arbiter: instr/data ports onto one pipelined memory port. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              instr_gnt,
  output logic [DATA_W-1:0] instr_rdata,
  output logic              instr_err,
  output logic              instr_valid,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [BE_W-1:0]   data_be,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_err,
  output logic              data_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  input  logic              mem_valid,
  output logic              protocol_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  src_id_t           w_sel;
  src_id_t           w_pop_id;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic              w_full;
  logic [SW-1:0]     r_starve;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_wdata;
  logic [BE_W-1:0]   r_hold_be;
  logic              r_hold_we;
  logic              r_perr;
  logic              w_grant;
  logic              w_pop;
  logic              w_starved;

  assign mem_req   = (instr_req | data_req) & (w_count < CW'(MAX_OUTSTANDING)) & ~reset;
  assign w_grant   = mem_req & mem_gnt;
  assign w_starved = instr_req & (r_starve == SW'(STARVE_LIMIT));
  assign w_pop     = mem_valid & ~w_empty & ~reset;

  always_comb begin
    w_sel = SRC_INSTR;
    case (r_state)
      ARB_HOLD_I: w_sel = SRC_INSTR;
      ARB_HOLD_D: w_sel = SRC_DATA;
      default:    w_sel = (data_req && !w_starved) ? SRC_DATA : SRC_INSTR;
    endcase
  end

  // While holding, the bus replays the values captured when the stall began.
  always_comb begin
    mem_addr  = instr_addr;
    mem_we    = 1'b0;
    mem_be    = 4'hF;
    mem_wdata = '0;
    if (r_state != ARB_IDLE) begin
      mem_addr  = r_hold_addr;
      mem_we    = r_hold_we;
      mem_be    = r_hold_be;
      mem_wdata = r_hold_wdata;
    end else if (w_sel == SRC_DATA) begin
      mem_addr  = data_addr;
      mem_we    = data_we;
      mem_be    = data_be;
      mem_wdata = data_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (mem_req && !mem_gnt) begin
          w_state_nxt = (w_sel == SRC_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
        end
      end
      ARB_HOLD_I, ARB_HOLD_D: begin
        if (w_full) begin
          w_state_nxt = r_state;
        end else if (w_grant) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_addr  <= '0;
      r_hold_we    <= 1'b0;
      r_hold_be    <= '0;
      r_hold_wdata <= '0;
    end else if (r_state == ARB_IDLE && mem_req && !mem_gnt) begin
      r_hold_addr  <= mem_addr;
      r_hold_we    <= mem_we;
      r_hold_be    <= mem_be;
      r_hold_wdata <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !instr_req) begin
      r_starve <= '0;
    end else if (w_grant && w_sel == SRC_INSTR) begin
      r_starve <= '0;
    end else if (w_grant && r_starve != SW'(STARVE_LIMIT)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perr <= 1'b0;
    end else if (mem_valid && w_empty) begin
      r_perr <= 1'b1;
    end
  end

  outstanding_tracker #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .push    (w_grant),
    .push_id (w_sel),
    .pop     (w_pop),
    .pop_id  (w_pop_id),
    .count   (w_count),
    .empty   (w_empty),
    .full    (w_full)
  );

  assign instr_gnt    = w_grant & (w_sel == SRC_INSTR);
  assign data_gnt     = w_grant & (w_sel == SRC_DATA);
  assign instr_valid  = w_pop & (w_pop_id == SRC_INSTR);
  assign data_valid   = w_pop & (w_pop_id == SRC_DATA);
  assign instr_rdata  = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign instr_err    = mem_err;
  assign data_err     = mem_err;
  assign protocol_err = r_perr;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ------------------------------------------------------------------------
// tb_mem_port_arbiter: directed vector bench for mem_port_arbiter. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        instr_valid;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        data_valid;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        mem_valid;
  logic        protocol_err;

  mem_port_arbiter #(
    .MAX_OUTSTANDING (2),
    .STARVE_LIMIT    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_gnt    (instr_gnt),
    .instr_rdata  (instr_rdata),
    .instr_err    (instr_err),
    .instr_valid  (instr_valid),
    .data_req     (data_req),
    .data_we      (data_we),
    .data_be      (data_be),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_gnt     (data_gnt),
    .data_rdata   (data_rdata),
    .data_err     (data_err),
    .data_valid   (data_valid),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rdata    (mem_rdata),
    .mem_err      (mem_err),
    .mem_valid    (mem_valid),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ireq, dreq, dwe, mgnt, mvalid;
    logic [31:0] daddr, rdata;
    logic        bus;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_we, e_igt, e_dgt, e_iv, e_dv, e_perr;
  } vec_t;

  vec_t vecs [32];
  int   nv = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic exp_i, prev_i;

  localparam logic [31:0] WDATA = 32'hCAFE_0001;

  function automatic vec_t mk(
    input logic rst, ireq, dreq, dwe, mgnt, mvalid,
    input logic [31:0] daddr, rdata,
    input logic bus, e_req,
    input logic [31:0] e_addr,
    input logic e_we, e_igt, e_dgt, e_iv, e_dv, e_perr);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.dwe = dwe; v.mgnt = mgnt;
    v.mvalid = mvalid; v.daddr = daddr; v.rdata = rdata; v.bus = bus;
    v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we; v.e_igt = e_igt;
    v.e_dgt = e_dgt; v.e_iv = e_iv; v.e_dv = e_dv; v.e_perr = e_perr;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[nv] = v;
    nv++;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    instr_req = 0; data_req = 0; data_we = 0; mem_gnt = 0; mem_valid = 0;
    mem_rdata = 0; mem_err = 0; data_addr = 32'h100;
  endtask

  initial begin
    // Fields: rst ireq dreq dwe mgnt mvalid daddr rdata | bus req addr we igt dgt iv dv perr
    add(mk(0,0,0,0,0,0, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,0)); // reset state
    add(mk(0,1,0,0,1,0, 32'h100, 32'h13,       1, 1, 32'h80,  0, 1,0,0,0,0)); // instr fetch granted
    add(mk(0,0,0,0,0,1, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,1,0,0)); // zero-latency response
    add(mk(0,0,1,1,0,0, 32'h100, 32'h13,       1, 1, 32'h100, 1, 0,0,0,0,0)); // data write stalls
    add(mk(0,1,1,1,0,0, 32'h200, 32'h13,       1, 1, 32'h100, 1, 0,0,0,0,0)); // held despite new addr
    add(mk(0,1,1,1,0,0, 32'h200, 32'h13,       1, 1, 32'h100, 1, 0,0,0,0,0));
    add(mk(0,1,1,1,1,0, 32'h200, 32'h13,       1, 1, 32'h100, 1, 0,1,0,0,0)); // held write granted
    add(mk(0,1,0,0,1,0, 32'h200, 32'h13,       1, 1, 32'h80,  0, 1,0,0,0,0)); // second outstanding
    add(mk(0,1,1,0,1,0, 32'h200, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,0)); // full: req gated
    add(mk(0,1,0,0,1,1, 32'h200, 32'hAAAA5555, 0, 0, 32'h0,   0, 0,0,0,1,0)); // pop goes to data
    add(mk(0,1,0,0,1,0, 32'h200, 32'h13,       1, 1, 32'h80,  0, 1,0,0,0,0)); // req back next cycle
    add(mk(0,0,0,0,0,1, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,1,0,0));
    add(mk(0,0,0,0,0,1, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,1,0,0));
    add(mk(0,0,0,0,0,1, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,0)); // stray response
    add(mk(0,0,0,0,0,0, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,1)); // sticky flag
    add(mk(0,0,0,0,0,0, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,1));
    add(mk(1,1,0,0,1,0, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,1)); // reset: no grant
    add(mk(0,0,0,0,0,0, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,0)); // flag cleared
    add(mk(0,1,0,0,1,0, 32'h100, 32'h13,       1, 1, 32'h80,  0, 1,0,0,0,0)); // outstanding fetch
    add(mk(1,0,0,0,0,0, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,0)); // reset mid-flight
    add(mk(0,0,0,0,0,1, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,0)); // late response dropped
    add(mk(0,0,0,0,0,0, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,1));
    add(mk(1,0,0,0,0,0, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,1));
    add(mk(0,0,0,0,0,0, 32'h100, 32'h13,       0, 0, 32'h0,   0, 0,0,0,0,0));

    instr_addr = 32'h80; data_be = 4'h3; data_wdata = WDATA;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; instr_req = vecs[i].ireq; data_req = vecs[i].dreq;
      data_we = vecs[i].dwe; mem_gnt = vecs[i].mgnt; mem_valid = vecs[i].mvalid;
      data_addr = vecs[i].daddr; mem_rdata = vecs[i].rdata; mem_err = vecs[i].rdata[31];
      #1;
      chk($sformatf("vec%0d_ctl", i),
          {90'd0, mem_req, instr_gnt, data_gnt, instr_valid, data_valid, protocol_err},
          {90'd0, vecs[i].e_req, vecs[i].e_igt, vecs[i].e_dgt, vecs[i].e_iv, vecs[i].e_dv, vecs[i].e_perr});
      if (vecs[i].bus)
        chk($sformatf("vec%0d_bus", i), {27'd0, mem_addr, mem_we, mem_be, mem_wdata},
            {27'd0, vecs[i].e_addr, vecs[i].e_we, vecs[i].e_we ? 4'h3 : 4'hF,
             vecs[i].e_we ? WDATA : 32'h0});
      if (vecs[i].e_iv || vecs[i].e_dv)
        chk($sformatf("vec%0d_rsp", i), {30'd0, instr_rdata, data_rdata, instr_err, data_err},
            {30'd0, vecs[i].rdata, vecs[i].rdata, vecs[i].rdata[31], vecs[i].rdata[31]});
    end

    // Both sources hammering with back-to-back grants and responses.
    @(negedge clk); idle_inputs(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    prev_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      instr_req = 1; data_req = 1; data_we = 0; mem_gnt = 1;
      mem_valid = (i > 0); mem_rdata = 32'h1000 + i;
      #1;
      exp_i = ((i % 5) == 4);
      chk($sformatf("starve_gnt%0d", i), {93'd0, mem_req, instr_gnt, data_gnt},
          {93'd0, 1'b1, exp_i, !exp_i});
      if (i > 0)
        chk($sformatf("order%0d", i), {93'd0, instr_valid, data_valid, protocol_err},
            {93'd0, prev_i, !prev_i, 1'b0});
      prev_i = exp_i;
      @(negedge clk);
    end
    idle_inputs(); mem_valid = 1;
    #1 chk("drain_last", {94'd0, instr_valid, data_valid}, {94'd0, prev_i, !prev_i});
    @(negedge clk); mem_valid = 1;
    #1 chk("drain_empty", {93'd0, instr_valid, data_valid, protocol_err}, 96'd0);
    @(negedge clk); mem_valid = 0;
    #1 chk("drain_perr", {95'd0, protocol_err}, {95'd0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, max accepted-but-unanswered memory transactions (range 1..4).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants allowed while instr_req waits.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have instruction-side ports:
- instr_req in 1
- instr_addr in 32
- instr_gnt out 1
- instr_rdata out 32
- instr_err out 1
- instr_valid out 1
REQ-006 SHALL have data-side ports:
- data_req in 1
- data_we in 1
- data_be in 4
- data_addr in 32
- data_wdata in 32
- data_gnt out 1
- data_rdata out 32
- data_err out 1
- data_valid out 1
REQ-007 SHALL have memory-side ports:
- mem_req out 1
- mem_we out 1
- mem_be out 4
- mem_addr out 32
- mem_wdata out 32
- mem_gnt in 1
- mem_rdata in 32
- mem_err in 1
- mem_valid in 1
REQ-008 SHALL have port protocol_err, output, 1: sticky flag, set on a response with no outstanding transaction.

Function
REQ-009 SHALL drive mem_req = (instr_req | data_req) & (count < MAX_OUTSTANDING), where count is the number of outstanding transactions.
REQ-010 SHALL use FSM states ARB_IDLE, ARB_HOLD_I, ARB_HOLD_D.
REQ-011 In ARB_IDLE, SHALL select data when data_req=1, unless both of these hold, in which case it selects instruction:
- instr_req=1
- starve_cnt == STARVE_LIMIT
REQ-012 In ARB_IDLE with no data_req, SHALL select instruction when instr_req=1.
REQ-013 When mem_req=1 and mem_gnt=0, SHALL transition from ARB_IDLE to ARB_HOLD_I or ARB_HOLD_D (matching the selection) and keep that selection, with address, we, be and wdata unchanged, until mem_gnt.
REQ-014 SHALL return from a HOLD state to ARB_IDLE on mem_gnt.
REQ-015 SHALL stay in a HOLD state, without re-arbitrating, while count == MAX_OUTSTANDING.
REQ-016 For an instruction selection, SHALL drive mem_we=0, mem_be=4'hF, mem_wdata=0.
REQ-017 SHALL assert instr_gnt / data_gnt = mem_gnt & mem_req, to the selected source only; the unselected gnt SHALL be 0 combinationally.
REQ-018 On mem_req & mem_gnt, SHALL push the source ID (0=instr, 1=data) into an in-order tracking FIFO.
REQ-019 On mem_valid with FIFO non-empty, SHALL pop the FIFO and route the response to the popped source:
- that source's valid = 1, in the same cycle (zero latency)
- the other source's valid = 0
REQ-020 SHALL drive instr_rdata, data_rdata, instr_err and data_err as pass-through of mem_rdata and mem_err on both sides.
REQ-021 SHALL ignore mem_valid with FIFO empty, set protocol_err=1, and leave count unchanged.
REQ-022 On simultaneous grant and response in one cycle, SHALL push and pop together, leaving count unchanged.
REQ-023 SHALL handle a response in the same cycle as a grant when count == MAX_OUTSTANDING as follows:
- the pop frees the slot
- mem_req stays gated by the registered count
REQ-024 SHALL update starve_cnt as follows:
- +1 on each data grant while instr_req=1, saturating at STARVE_LIMIT
- cleared on instruction grant
- cleared when instr_req=0

Reset
REQ-025 On reset=1 at a clock edge, SHALL set: FSM=ARB_IDLE, count=0, FIFO empty, starve_cnt=0, protocol_err=0.
REQ-026 With reset=1, all gnt/valid/req outputs SHALL evaluate to 0 from the next edge.
REQ-027 On reset mid-transaction, SHALL discard outstanding IDs, and SHALL flag responses arriving after reset as protocol_err.

Structure
REQ-028 Package riscv_mem_pkg SHALL hold arb_state_t, the src_id_t enum (SRC_INSTR=0, SRC_DATA=1) and the 32-bit width localparams.
REQ-029 SHALL contain exactly one sub-module, outstanding_tracker: a parameterised ID FIFO with push, pop, count, empty and full.

Verification
REQ-030 Bench SHALL cover: instr_req only, addr 0x80, mem_gnt same cycle, mem_valid 1 cycle later with rdata 0x00000013 -> instr_gnt=1, then instr_valid=1 with rdata 0x13, data_valid=0.
REQ-031 Bench SHALL cover: instr_req and data_req both held, mem_gnt always 1, STARVE_LIMIT=4 -> 4 data grants, then 1 instr grant, repeating.
REQ-032 Bench SHALL cover: data write addr 0x100, mem_gnt held 0 for 3 cycles, instr_req rising meanwhile -> mem_addr stays 0x100, mem_we=1, instr_gnt=0 until the grant.
REQ-033 Bench SHALL cover: MAX_OUTSTANDING=2, two grants without response -> mem_req=0; then one mem_valid -> mem_req=1 next cycle, and the response goes to the first-granted source.
REQ-034 Bench SHALL cover: mem_valid with FIFO empty -> protocol_err=1 and held; reset=1 for one cycle -> protocol_err=0.
REQ-035 Bench SHALL cover: grant and response in the same cycle at count=1 -> count stays 1, ordering preserved across 8 mixed transactions.
